// File: rtl/pe_nic.sv
// NIC between a PE register map and the router PE port: one 64-bit TX buffer, one 64-bit RX buffer.
// TX pulses net_so one edge after a write at the earliest; net_ri low or a VC-phase mismatch holds TX; a full RX buffer drops net_ro.
module pe_nic #(
  parameter int DATA_W   = 64,
  parameter int VC_BIT   = 63,
  parameter int POL_GATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_ri,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_ro,
  input  logic              net_polarity
);

  localparam logic [1:0] ADDR_IBUF  = 2'd0;
  localparam logic [1:0] ADDR_ISTAT = 2'd1;
  localparam logic [1:0] ADDR_OBUF  = 2'd2;
  localparam logic [1:0] ADDR_OSTAT = 2'd3;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_PULSE = 1'b1
  } tx_state_t;

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [DATA_W-1:0]  r_out_buf;
  logic               r_out_full;
  logic [DATA_W-1:0]  r_in_buf;
  logic               r_in_full;
  logic [DATA_W-1:0]  r_net_do;
  logic [DATA_W-1:0]  r_d_out;
  logic [DATA_W-1:0]  w_rd_dat;
  logic               w_launch;
  logic               w_pol_ok;
  logic               w_rd;
  logic               w_wr_ok;
  logic               w_cap;

  // Packets only enter the router on their own virtual-channel phase.
  assign w_pol_ok = (POL_GATE == 0) || (r_out_buf[VC_BIT] == net_polarity);
  assign w_rd     = nicEn && !nicWrEn;
  assign w_wr_ok  = nicEn && nicWrEn && (addr == ADDR_OBUF) && !r_out_full;
  assign w_cap    = net_si && !r_in_full;

  assign net_so = (r_state == TX_PULSE);
  assign net_do = r_net_do;
  assign net_ro = !r_in_full;
  assign d_out  = r_d_out;

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (r_out_full && net_ri && w_pol_ok) begin
          w_launch    = 1'b1;
          w_state_nxt = TX_PULSE;
        end
      end
      TX_PULSE: w_state_nxt = TX_IDLE;
      default:  w_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rd_dat = '0;
    case (addr)
      ADDR_IBUF:  w_rd_dat = r_in_buf;
      ADDR_ISTAT: w_rd_dat = {{(DATA_W-1){1'b0}}, r_in_full};
      ADDR_OBUF:  w_rd_dat = r_out_buf;
      ADDR_OSTAT: w_rd_dat = {{(DATA_W-1){1'b0}}, r_out_full};
      default:    w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= TX_IDLE;
      r_net_do <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_net_do <= w_launch ? r_out_buf : '0;
    end
  end

  // A write landing on the launch edge sees out_full=1 and is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_launch) begin
      r_out_full <= 1'b0;
    end else if (w_wr_ok) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end
  end

  // Capture beats a same-edge addr0 read; net_si while full is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_cap) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd && (addr == ADDR_IBUF)) begin
      r_in_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      r_d_out <= w_rd_dat;
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Directed test-plan scenarios plus randomized traffic checked against a packet-level model of the NIC.
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ri = 1'b0;
  logic        net_si = 1'b0;
  logic [63:0] net_di = '0;
  logic        net_ro;
  logic        net_polarity = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Model: contents of each buffer, whether it is occupied, what the PE last read,
  // and what the router should see on its injection port during the current cycle.
  logic [63:0] m_obuf, m_ibuf, m_dout, m_do;
  bit          m_ofull, m_ifull, m_so;

  pe_nic #(.DATA_W(64), .VC_BIT(63), .POL_GATE(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_do(net_do),
    .net_ri(net_ri), .net_si(net_si), .net_di(net_di), .net_ro(net_ro),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_obuf = '0; m_ibuf = '0; m_dout = '0; m_do = '0;
    m_ofull = 0; m_ifull = 0; m_so = 0;
  endtask

  // Called at a negedge; drives one cycle of inputs, advances the model across the
  // following rising edge and compares every output at the next negedge.
  task automatic cyc(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] din,
                     input bit ri, input bit si, input logic [63:0] di, input bit pol);
    bit          send, rd;
    logic [63:0] n_obuf, n_ibuf, n_dout;
    bit          n_ofull, n_ifull;
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ri = ri; net_si = si; net_di = di; net_polarity = pol;
    // A packet leaves only if nothing was sent last cycle, the router is ready
    // and the packet's VC bit matches the current phase.
    send    = !m_so && m_ofull && ri && (m_obuf[63] == pol);
    rd      = en && !wr;
    n_obuf  = m_obuf;  n_ofull = m_ofull;
    n_ibuf  = m_ibuf;  n_ifull = m_ifull;
    n_dout  = m_dout;
    if (send) n_ofull = 0;
    else if (en && wr && a == 2'd2 && !m_ofull) begin n_obuf = din; n_ofull = 1; end
    if (si && !m_ifull) begin n_ibuf = di; n_ifull = 1; end
    else if (rd && a == 2'd0) n_ifull = 0;
    if (rd) begin
      case (a)
        2'd0: n_dout = m_ibuf;
        2'd1: n_dout = 64'(m_ifull);
        2'd2: n_dout = m_obuf;
        default: n_dout = 64'(m_ofull);
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    m_do = send ? m_obuf : 64'd0;
    m_so = send;
    m_obuf = n_obuf; m_ofull = n_ofull; m_ibuf = n_ibuf; m_ifull = n_ifull; m_dout = n_dout;
    chk("net_so", 64'(net_so), 64'(m_so));
    chk("net_do", net_do, m_do);
    chk("net_ro", 64'(net_ro), 64'(!m_ifull));
    chk("d_out", d_out, m_dout);
  endtask

  task automatic idle(input bit ri, input bit pol);
    cyc(0, 0, 2'd0, 64'd0, ri, 0, 64'd0, pol);
  endtask

  task automatic rd(input logic [1:0] a, input bit ri, input bit pol);
    cyc(1, 0, a, 64'd0, ri, 0, 64'd0, pol);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_ro", 64'(net_ro), 64'd1);
    chk("rst_dout", d_out, 64'd0);
    chk("rst_do", net_do, 64'd0);
    model_clear();
    nicEn = 0; nicWrEn = 0; net_si = 0; net_ri = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Basic TX
    cyc(1, 1, 2'd2, 64'h200200000000FA50, 1, 0, 64'd0, 0);
    chk("tx_no_early", 64'(net_so), 64'd0);
    idle(1, 0);
    chk("tx_pulse", 64'(net_so), 64'd1);
    chk("tx_data", net_do, 64'h200200000000FA50);
    idle(1, 0);
    chk("tx_pulse_end", 64'(net_so), 64'd0);
    rd(2'd3, 1, 0);
    chk("tx_ostat", d_out, 64'd0);

    // Polarity gate
    cyc(1, 1, 2'd2, 64'h800000000000ABCD, 1, 0, 64'd0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 0);
      chk("pol_hold", 64'(net_so), 64'd0);
    end
    idle(1, 1);
    chk("pol_pulse", 64'(net_so), 64'd1);
    chk("pol_data", net_do, 64'h800000000000ABCD);
    idle(1, 1);
    chk("pol_single", 64'(net_so), 64'd0);

    // Back-pressure and dropped write
    cyc(1, 1, 2'd2, 64'h1111, 0, 0, 64'd0, 0);
    cyc(1, 1, 2'd2, 64'h2222, 0, 0, 64'd0, 0);
    rd(2'd2, 0, 0);
    chk("bp_obuf", d_out, 64'h1111);
    rd(2'd3, 0, 0);
    chk("bp_ostat", d_out, 64'd1);
    idle(1, 0);
    chk("bp_pulse", 64'(net_so), 64'd1);
    chk("bp_data", net_do, 64'h1111);
    for (int i = 0; i < 3; i++) begin
      idle(1, 0);
      chk("bp_no_second", 64'(net_so), 64'd0);
    end

    // RX, then overflow while full
    cyc(0, 0, 2'd0, 64'd0, 0, 1, 64'h2002000000006840, 0);
    chk("rx_ro_low", 64'(net_ro), 64'd0);
    rd(2'd1, 0, 0);
    chk("rx_istat", d_out, 64'd1);
    cyc(0, 0, 2'd0, 64'd0, 0, 1, 64'hDEAD, 0);
    rd(2'd0, 0, 0);
    chk("rx_data", d_out, 64'h2002000000006840);
    chk("rx_ro_high", 64'(net_ro), 64'd1);
    rd(2'd0, 0, 0);
    chk("rx_stale", d_out, 64'h2002000000006840);

    // Reset mid-pulse with RX buffer full
    cyc(0, 0, 2'd0, 64'd0, 0, 1, 64'h55AA, 0);
    cyc(1, 1, 2'd2, 64'h0000000000003333, 1, 0, 64'd0, 0);
    idle(1, 0);
    chk("pre_rst_so", 64'(net_so), 64'd1);
    do_reset();
    rd(2'd1, 0, 0);
    chk("post_rst_istat", d_out, 64'd0);
    rd(2'd3, 0, 0);
    chk("post_rst_ostat", d_out, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          en, wr, ri, si, pol;
      logic [1:0]  a;
      logic [63:0] din, di;
      en  = ($urandom_range(0, 99) < 40);
      wr  = $urandom_range(0, 1) == 1;
      a   = 2'($urandom_range(0, 3));
      if (wr && $urandom_range(0, 1) == 1) a = 2'd2;
      din = {$urandom, $urandom};
      di  = {$urandom, $urandom};
      ri  = ($urandom_range(0, 99) < 70);
      si  = ($urandom_range(0, 99) < 25);
      pol = ($urandom_range(0, 99) < 50);
      cyc(en, wr, a, din, ri, si, di, pol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
